fifo_ctrl: RTL

Synchronous single-clock FIFO controller that sequences a dual-port RAM as circular storage: port 1 (synchronous write) for the write side, port 0 (asynchronous read) for the read side. It owns the read/write pointers, occupancy count and status flags, and presents valid/ready handshakes on both sides. It sits between a producer and a consumer in the `module/fifo` hierarchy, with the RAM instantiated beside it in the FIFO top.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_ptr.sv | 29 ++
 rtl/fifo_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the FIFO controller slice.
//   ADDR_WIDTH_DEF : default RAM address width
//   DEPTH          : default number of entries (1 << ADDR_WIDTH_DEF)
//   count_t        : occupancy type for the default geometry (0..DEPTH)
//   op_e           : per-cycle operation, encoded as {push, pop}
//   fifo_depth()   : entry count for an arbitrary address width
package fifo_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DEPTH          = 1 << ADDR_WIDTH_DEF;

    typedef logic [ADDR_WIDTH_DEF:0] count_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr
// Wrapping address counter used for both the write and the read pointer.
//   clk  : clock
//   rst  : asynchronous active-high reset (pointer to 0)
//   clr  : synchronous clear (flush)
//   inc  : advance by one; rolls from 2^WIDTH-1 to 0
//   ptr  : current pointer value
module fifo_ptr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of always-block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + 1'b1;  // natural modulo-2^WIDTH wrap
    end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl
// Single-clock FIFO controller driving an external dual-port RAM
// (port 1 synchronous write, port 0 asynchronous read) as circular storage.
//   clk, rst           : clock, asynchronous active-high reset
//   flush              : synchronous clear; overrides push and pop
//   wr_valid/wr_data   : producer side; wr_ready = ~full
//   rd_valid/rd_data   : consumer side (show-ahead); rd_ready takes the head
//   ram_wr_addr/ram_wr_data/ram_we : RAM port 1
//   ram_rd_addr/ram_rd_data        : RAM port 0
//   count              : occupancy 0..2^ADDR_WIDTH
//   full/empty/almost_full/almost_empty : registered status flags
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(fifo_depth(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LVL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LVL);

    logic                push;
    logic                pop;
    logic                do_push;
    logic                do_pop;
    op_e                 op;
    logic [ADDR_WIDTH:0] next_count;

    assign wr_ready = ~full;
    assign rd_valid = ~empty;

    // Each handshake depends only on its own side's registered flag.
    assign push = wr_valid & wr_ready;
    assign pop  = rd_valid & rd_ready;

    // Flush and reset both suppress the RAM write and pointer movement.
    assign do_push = push & ~flush & ~rst;
    assign do_pop  = pop  & ~flush & ~rst;

    // The RAM itself is never reset: stale words sit behind rd_ptr and are
    // only read again after being rewritten.
    assign ram_we      = do_push;
    assign ram_wr_data = wr_data;
    assign rd_data     = ram_rd_data;

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (do_push),
        .ptr (ram_wr_addr)
    );

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (do_pop),
        .ptr (ram_rd_addr)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        op         = op_e'({do_push, do_pop});
        next_count = count;
        if (flush) begin
            next_count = '0;
        end else begin
            case (op)
                OP_PUSH: next_count = count + 1'b1;
                OP_POP:  next_count = count - 1'b1;
                default: next_count = count;  // none, or push+pop together
            endcase
        end
    end

    // Flags are registered from next_count so they line up with count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= next_count;
            full         <= (next_count == DEPTH_C);
            empty        <= (next_count == '0);
            almost_full  <= (next_count >= AFULL_C);
            almost_empty <= (next_count <= AEMPTY_C);
        end
    end

endmodule
